// File: rtl/multi_mode_ff_reg.sv
// WIDTH-bit bank of run-time-selectable SR/JK/D/T flip-flops with sticky SR error capture.
// Define MMFF_TOGGLE_CNT_EN to add the saturating toggle counter (toggle_cnt, clr_cnt).
module multi_mode_ff_reg #(
    parameter int unsigned      WIDTH         = 8,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0,
    parameter int unsigned      SR_INV_POLICY = 0,
    parameter int unsigned      CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] err_mask,
    output logic             sr_err
`ifdef MMFF_TOGGLE_CNT_EN
    ,
    output logic [CNT_W-1:0] toggle_cnt,
    input  logic             clr_cnt
`endif
);

    typedef enum logic [1:0] {
        MODE_SR = 2'b00,
        MODE_JK = 2'b01,
        MODE_D  = 2'b10,
        MODE_T  = 2'b11
    } mode_e;

    mode_e            mode_sel;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] err_set;
    logic [WIDTH-1:0] sr_both;
    logic [WIDTH-1:0] sr_inv;

    assign mode_sel = mode_e'(mode);

    // Vector form of the per-bit tables; S=R=1 bits are patched in via sr_inv.
    always_comb begin
        sr_both = a & b;
        case (SR_INV_POLICY)
            1:       sr_inv = '1;
            2:       sr_inv = '0;
            default: sr_inv = q;
        endcase
        q_next  = q;
        err_set = '0;
        if (en) begin
            unique case (mode_sel)
                MODE_SR: begin
                    q_next  = (((q | a) & ~b) & ~sr_both) | (sr_inv & sr_both);
                    err_set = sr_both;
                end
                MODE_JK: q_next = (a & ~q) | (~b & q);
                MODE_D:  q_next = a;
                MODE_T:  q_next = q ^ a;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VAL;
        end else begin
            q <= q_next;
        end
    end

    // A fresh S=R=1 on the clearing edge survives the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_mask <= '0;
        end else if (clr_err) begin
            err_mask <= err_set;
        end else begin
            err_mask <= err_mask | err_set;
        end
    end

    assign qn     = ~q;
    assign sr_err = |err_mask;

`ifdef MMFF_TOGGLE_CNT_EN
    localparam int unsigned PC_W  = $clog2(WIDTH + 1);
    localparam int unsigned SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

    logic [WIDTH-1:0] flips;
    logic [SUM_W-1:0] flip_cnt;
    logic [SUM_W-1:0] cnt_sum;

    always_comb begin
        flips    = q_next ^ q;
        flip_cnt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            flip_cnt = flip_cnt + SUM_W'(flips[i]);
        end
        cnt_sum = SUM_W'(toggle_cnt) + flip_cnt;
    end

    // Any carry above CNT_W bits means the counter would wrap; pin it at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            toggle_cnt <= '0;
        end else if (clr_cnt) begin
            toggle_cnt <= '0;
        end else if (en) begin
            toggle_cnt <= (|cnt_sum[SUM_W-1:CNT_W]) ? '1 : cnt_sum[CNT_W-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_multi_mode_ff_reg.sv
// Scoreboard bench for multi_mode_ff_reg: three instances differing only in SR_INV_POLICY.
// Counter checks are compiled in when MMFF_TOGGLE_CNT_EN is defined.
module tb_multi_mode_ff_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       clr_err = 1'b0;
    logic       clr_cnt = 1'b0;

    logic [7:0] q0, q1, q2, qn0, qn1, qn2, e0, e1, e2;
    logic       s0, s1, s2;
    logic [3:0] cnt0, cnt1, cnt2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         id;
        logic [7:0] q0, q1, q2;
        logic [7:0] e0, e1, e2;
        logic       chk_cnt;
        logic [3:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    multi_mode_ff_reg #(.WIDTH(8), .RESET_VAL(8'h00), .SR_INV_POLICY(0), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
        .q(q0), .qn(qn0), .err_mask(e0), .sr_err(s0)
`ifdef MMFF_TOGGLE_CNT_EN
        , .toggle_cnt(cnt0), .clr_cnt(clr_cnt)
`endif
    );

    multi_mode_ff_reg #(.WIDTH(8), .RESET_VAL(8'h00), .SR_INV_POLICY(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
        .q(q1), .qn(qn1), .err_mask(e1), .sr_err(s1)
`ifdef MMFF_TOGGLE_CNT_EN
        , .toggle_cnt(cnt1), .clr_cnt(clr_cnt)
`endif
    );

    multi_mode_ff_reg #(.WIDTH(8), .RESET_VAL(8'h00), .SR_INV_POLICY(2), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
        .q(q2), .qn(qn2), .err_mask(e2), .sr_err(s2)
`ifdef MMFF_TOGGLE_CNT_EN
        , .toggle_cnt(cnt2), .clr_cnt(clr_cnt)
`endif
    );

`ifndef MMFF_TOGGLE_CNT_EN
    assign cnt0 = 4'h0;
    assign cnt1 = 4'h0;
    assign cnt2 = 4'h0;
`endif

    function automatic exp_t mk(input int id, input logic [7:0] xq0, xq1, xq2, xe0, xe1, xe2);
        exp_t x;
        x.id = id;
        x.q0 = xq0; x.q1 = xq1; x.q2 = xq2;
        x.e0 = xe0; x.e1 = xe1; x.e2 = xe2;
        x.chk_cnt = 1'b0;
        x.cnt = 4'h0;
        return x;
    endfunction

    function automatic exp_t mk3(input int id, input logic [7:0] xq, xe);
        return mk(id, xq, xq, xq, xe, xe, xe);
    endfunction

    function automatic exp_t mkc(input int id, input logic [7:0] xq, xe, input logic [3:0] c);
        exp_t x;
        x = mk3(id, xq, xe);
        x.chk_cnt = 1'b1;
        x.cnt = c;
        return x;
    endfunction

    task automatic chk(input int id, input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL step%0d %s got %h expected %h", id, nm, act, exp);
        end
    endtask

    // Monitor: outputs are sampled 1 time unit after each clock edge or reset assertion.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk or posedge rst);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk(x.id, "q0", q0, x.q0);
                chk(x.id, "q1", q1, x.q1);
                chk(x.id, "q2", q2, x.q2);
                chk(x.id, "qn0", qn0, ~x.q0);
                chk(x.id, "qn1", qn1, ~x.q1);
                chk(x.id, "qn2", qn2, ~x.q2);
                chk(x.id, "err0", e0, x.e0);
                chk(x.id, "err1", e1, x.e1);
                chk(x.id, "err2", e2, x.e2);
                chk(x.id, "sr_err0", {7'd0, s0}, {7'd0, |x.e0});
                chk(x.id, "sr_err1", {7'd0, s1}, {7'd0, |x.e1});
                chk(x.id, "sr_err2", {7'd0, s2}, {7'd0, |x.e2});
`ifdef MMFF_TOGGLE_CNT_EN
                if (x.chk_cnt) begin
                    chk(x.id, "cnt0", {4'd0, cnt0}, {4'd0, x.cnt});
                    chk(x.id, "cnt2", {4'd0, cnt2}, {4'd0, x.cnt});
                end
`endif
            end
        end
    end

    task automatic step(input logic e_i, input logic [1:0] m_i, input logic [7:0] a_i, b_i,
                        input logic ce_i, cc_i, input exp_t x);
        @(negedge clk);
        en = e_i; mode = m_i; a = a_i; b = b_i; clr_err = ce_i; clr_cnt = cc_i;
        exp_q.push_back(x);
    endtask

    task automatic pulse_rst(input exp_t x);
        @(negedge clk);
        #2;
        en = 1'b0; clr_err = 1'b0; clr_cnt = 1'b0;
        exp_q.push_back(x);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: stimulus did not complete");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        exp_q.push_back(mk3(0, 8'h00, 8'h00));
        @(negedge clk);
        rst = 1'b0;

        step(1, 2'b10, 8'hA5, 8'h00, 0, 0, mk3(1, 8'hA5, 8'h00));
        pulse_rst(mk3(2, 8'h00, 8'h00));
        step(1, 2'b01, 8'hF0, 8'h0F, 0, 0, mk3(3, 8'hF0, 8'h00));
        step(1, 2'b01, 8'hFF, 8'hFF, 0, 0, mk3(4, 8'h0F, 8'h00));
        step(1, 2'b01, 8'hFF, 8'hFF, 0, 0, mk3(5, 8'hF0, 8'h00));
        step(1, 2'b10, 8'h00, 8'h00, 0, 0, mk3(6, 8'h00, 8'h00));
        step(1, 2'b00, 8'h03, 8'h01, 0, 0, mk(7, 8'h02, 8'h03, 8'h02, 8'h01, 8'h01, 8'h01));
        step(1, 2'b00, 8'h00, 8'h00, 1, 0, mk(8, 8'h02, 8'h03, 8'h02, 8'h00, 8'h00, 8'h00));
        step(1, 2'b00, 8'hFF, 8'hFF, 0, 0, mk(9, 8'h02, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF));
        step(1, 2'b00, 8'h04, 8'h04, 1, 0, mk(10, 8'h02, 8'hFF, 8'h00, 8'h04, 8'h04, 8'h04));
        step(0, 2'b00, 8'hFF, 8'hFF, 0, 0, mk(11, 8'h02, 8'hFF, 8'h00, 8'h04, 8'h04, 8'h04));
        step(0, 2'b00, 8'hFF, 8'hFF, 1, 0, mk(12, 8'h02, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00));
        step(1, 2'b10, 8'h3C, 8'h00, 0, 0, mk3(13, 8'h3C, 8'h00));
        step(1, 2'b11, 8'hFF, 8'h00, 0, 0, mk3(14, 8'hC3, 8'h00));
        step(0, 2'b10, 8'h55, 8'hAA, 0, 0, mk3(15, 8'hC3, 8'h00));
        step(1, 2'b11, 8'h0F, 8'h00, 0, 0, mk3(16, 8'hCC, 8'h00));
        step(1, 2'b01, 8'h0F, 8'hF0, 0, 0, mk3(17, 8'h0F, 8'h00));

`ifdef MMFF_TOGGLE_CNT_EN
        pulse_rst(mkc(18, 8'h00, 8'h00, 4'd0));
        step(1, 2'b11, 8'hFF, 8'h00, 0, 0, mkc(19, 8'hFF, 8'h00, 4'd8));
        step(1, 2'b11, 8'hFF, 8'h00, 0, 0, mkc(20, 8'h00, 8'h00, 4'd15));
        step(1, 2'b11, 8'hFF, 8'h00, 0, 1, mkc(21, 8'hFF, 8'h00, 4'd0));
        step(1, 2'b11, 8'h01, 8'h00, 0, 0, mkc(22, 8'hFE, 8'h00, 4'd1));
`endif

        @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
